// File: rtl/pcie_perst_pkg.sv
// Shared types and constants for the PERST# sequencer.
package pcie_perst_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF       = 3'd0,
    ST_ASSERT    = 3'd1,
    ST_WAIT_LINK = 3'd2,
    ST_UP        = 3'd3,
    ST_FAIL      = 3'd4
  } perst_state_e;

  // Larger of two interval lengths; sizes the shared down-counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pcie_perst_gen_if.sv
// Pin-level bundle between the PERST# sequencer and its environment.
interface pcie_perst_gen_if #(
  parameter int MAX_RETRIES = 3
) ();
  import pcie_perst_pkg::*;

  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  logic               pwr_good;
  logic               link_up;
  logic               sw_reset_req;
  logic               perst_n;
  logic               link_ok;
  logic               fail;
  logic [RETRY_W-1:0] retry_cnt;
  logic [STATE_W-1:0] state_o;

  // Environment side: supplies status inputs, observes the sequencer.
  modport master (
    output pwr_good, link_up, sw_reset_req,
    input  perst_n, link_ok, fail, retry_cnt, state_o
  );

  // Sequencer side.
  modport slave (
    input  pwr_good, link_up, sw_reset_req,
    output perst_n, link_ok, fail, retry_cnt, state_o
  );
endinterface

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the async level through the synchronizer chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pcie_perst_gen.sv
// Root-port PERST# sequencer: timed release after power-good, link-up
// supervision with bounded retries, software-requested re-sequence.
module pcie_perst_gen
  import pcie_perst_pkg::*;
#(
  parameter int T_ASSERT       = 10_000_000,
  parameter int T_LINK_TIMEOUT = 10_000_000,
  parameter int MAX_RETRIES    = 3,
  parameter int SYNC_STAGES    = 2
) (
  input logic             clk,
  input logic             rst,
  pcie_perst_gen_if.slave bus
);

  localparam int CNT_MAX = max_int(T_ASSERT, T_LINK_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]   LOAD_ASSERT = CNT_W'(T_ASSERT - 1);
  localparam logic [CNT_W-1:0]   LOAD_LINK   = CNT_W'(T_LINK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_ZERO  = RETRY_W'(0);
  localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  logic pwr_good_s;
  logic link_up_s;
  logic sw_lvl_s;
  logic sw_prev_r;
  logic sw_req_s;

  perst_state_e       state_r, state_n;
  logic [CNT_W-1:0]   cnt_r, cnt_n;
  logic [RETRY_W-1:0] retry_r, retry_n;
  logic [RETRY_W-1:0] retry_inc_s;
  logic               perst_n_r, link_ok_r, fail_r;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_pwr  (.clk(clk), .rst(rst), .d(bus.pwr_good),     .q(pwr_good_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_link (.clk(clk), .rst(rst), .d(bus.link_up),      .q(link_up_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_sw   (.clk(clk), .rst(rst), .d(bus.sw_reset_req), .q(sw_lvl_s));

  // Remember last synchronized request level for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_prev_r <= 1'b0;
    end else begin
      sw_prev_r <= sw_lvl_s;
    end
  end

  assign sw_req_s = sw_lvl_s & ~sw_prev_r;

  // Next state, counter and retry count; power loss beats software request.
  always_comb begin
    state_n     = state_r;
    cnt_n       = (cnt_r == CNT_ZERO) ? CNT_ZERO : (cnt_r - CNT_ONE);
    retry_n     = retry_r;
    retry_inc_s = retry_r + RETRY_ONE;
    if (!pwr_good_s) begin
      state_n = ST_OFF;
    end else if (sw_req_s && (state_r != ST_OFF)) begin
      state_n = ST_ASSERT;
      cnt_n   = LOAD_ASSERT;
      retry_n = RETRY_ZERO;
    end else begin
      case (state_r)
        ST_OFF: begin
          state_n = ST_ASSERT;
          cnt_n   = LOAD_ASSERT;
        end
        ST_ASSERT: begin
          if (cnt_r == CNT_ZERO) begin
            state_n = ST_WAIT_LINK;
            cnt_n   = LOAD_LINK;
          end else begin
            state_n = ST_ASSERT;
          end
        end
        ST_WAIT_LINK: begin
          // A link-up seen on the timeout cycle still counts as success.
          if (link_up_s) begin
            state_n = ST_UP;
            retry_n = RETRY_ZERO;
          end else if (cnt_r == CNT_ZERO) begin
            retry_n = retry_inc_s;
            if (retry_inc_s == RETRY_LIMIT) begin
              state_n = ST_FAIL;
            end else begin
              state_n = ST_ASSERT;
              cnt_n   = LOAD_ASSERT;
            end
          end else begin
            state_n = ST_WAIT_LINK;
          end
        end
        ST_UP: begin
          // Link loss is not a training timeout, so the retry budget resets.
          if (!link_up_s) begin
            state_n = ST_ASSERT;
            cnt_n   = LOAD_ASSERT;
            retry_n = RETRY_ZERO;
          end else begin
            state_n = ST_UP;
          end
        end
        ST_FAIL: begin
          state_n = ST_FAIL;
        end
        default: begin
          state_n = ST_OFF;
        end
      endcase
    end
  end

  // State, counter and registered outputs all advance on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_OFF;
      cnt_r     <= CNT_ZERO;
      retry_r   <= RETRY_ZERO;
      perst_n_r <= 1'b0;
      link_ok_r <= 1'b0;
      fail_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      retry_r   <= retry_n;
      perst_n_r <= (state_n == ST_WAIT_LINK) || (state_n == ST_UP);
      link_ok_r <= (state_n == ST_UP);
      fail_r    <= (state_n == ST_FAIL);
    end
  end

  assign bus.perst_n   = perst_n_r;
  assign bus.link_ok   = link_ok_r;
  assign bus.fail      = fail_r;
  assign bus.retry_cnt = retry_r;
  assign bus.state_o   = state_r;

endmodule

// File: tb/tb_pcie_perst_gen.sv
// Directed scoreboard bench for pcie_perst_gen with short timing parameters.
module tb_pcie_perst_gen;

  localparam int T_ASSERT       = 16;
  localparam int T_LINK_TIMEOUT = 32;
  localparam int MAX_RETRIES    = 2;
  localparam int SYNC_STAGES    = 2;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb_q[$];
  int   n_assert;
  int   n_fail;
  int   n;

  pcie_perst_gen_if #(.MAX_RETRIES(MAX_RETRIES)) bus ();

  pcie_perst_gen #(
    .T_ASSERT(T_ASSERT),
    .T_LINK_TIMEOUT(T_LINK_TIMEOUT),
    .MAX_RETRIES(MAX_RETRIES),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d, nothing expected", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  // Ticks until perst_n reaches val or the budget runs out; returns cycles used.
  task automatic wait_perst(input logic val, input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while ((bus.perst_n !== val) && (cycles < budget));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b0;
    bus.pwr_good     = 1'b0;
    bus.link_up      = 1'b0;
    bus.sw_reset_req = 1'b0;

    // Reset values
    sb_push("rst_perst_n", 32'd0);
    sb_push("rst_link_ok", 32'd0);
    sb_push("rst_fail", 32'd0);
    sb_push("rst_retry", 32'd0);
    sb_push("rst_state", 32'd0);
    repeat (3) tick();
    sb_pop(32'(bus.perst_n));
    sb_pop(32'(bus.link_ok));
    sb_pop(32'(bus.fail));
    sb_pop(32'(bus.retry_cnt));
    sb_pop(32'(bus.state_o));
    rst = 1'b1;
    tick();

    // Power-up: release 2 sync + 1 decision + 16 assert cycles after pwr_good
    bus.pwr_good = 1'b1;
    sb_push("pwrup_release_cycles", 32'd19);
    sb_push("pwrup_state", 32'd2);
    wait_perst(1'b1, 100, n);
    sb_pop(32'(n));
    sb_pop(32'(bus.state_o));
    repeat (10) tick();
    bus.link_up = 1'b1;
    sb_push("up_link_ok", 32'd1);
    sb_push("up_state", 32'd3);
    sb_push("up_retry", 32'd0);
    sb_push("up_perst_n", 32'd1);
    repeat (3) tick();
    sb_pop(32'(bus.link_ok));
    sb_pop(32'(bus.state_o));
    sb_pop(32'(bus.retry_cnt));
    sb_pop(32'(bus.perst_n));

    // Link loss in UP
    bus.link_up = 1'b0;
    sb_push("loss_perst_n", 32'd0);
    sb_push("loss_link_ok", 32'd0);
    sb_push("loss_state", 32'd1);
    sb_push("loss_retry", 32'd0);
    repeat (3) tick();
    sb_pop(32'(bus.perst_n));
    sb_pop(32'(bus.link_ok));
    sb_pop(32'(bus.state_o));
    sb_pop(32'(bus.retry_cnt));
    sb_push("loss_reassert_cycles", 32'd16);
    wait_perst(1'b1, 100, n);
    sb_pop(32'(n));

    // First timeout
    sb_push("to1_cycles", 32'd32);
    sb_push("to1_retry", 32'd1);
    sb_push("to1_state", 32'd1);
    wait_perst(1'b0, 100, n);
    sb_pop(32'(n));
    sb_pop(32'(bus.retry_cnt));
    sb_pop(32'(bus.state_o));
    sb_push("to1_reassert_cycles", 32'd16);
    wait_perst(1'b1, 100, n);
    sb_pop(32'(n));

    // Second timeout reaches FAIL
    sb_push("to2_cycles", 32'd32);
    sb_push("fail_flag", 32'd1);
    sb_push("fail_state", 32'd4);
    sb_push("fail_retry", 32'd2);
    wait_perst(1'b0, 100, n);
    sb_pop(32'(n));
    sb_pop(32'(bus.fail));
    sb_pop(32'(bus.state_o));
    sb_pop(32'(bus.retry_cnt));
    sb_push("fail_hold_perst_n", 32'd0);
    sb_push("fail_hold_state", 32'd4);
    repeat (40) tick();
    sb_pop(32'(bus.perst_n));
    sb_pop(32'(bus.state_o));

    // Recovery from FAIL via software request
    bus.sw_reset_req = 1'b1;
    sb_push("rec_state", 32'd1);
    sb_push("rec_retry", 32'd0);
    sb_push("rec_fail", 32'd0);
    repeat (3) tick();
    sb_pop(32'(bus.state_o));
    sb_pop(32'(bus.retry_cnt));
    sb_pop(32'(bus.fail));
    bus.sw_reset_req = 1'b0;
    sb_push("rec_release_cycles", 32'd16);
    wait_perst(1'b1, 100, n);
    sb_pop(32'(n));

    // Power drop during WAIT_LINK
    repeat (5) tick();
    bus.pwr_good = 1'b0;
    sb_push("pdrop_state", 32'd0);
    sb_push("pdrop_perst_n", 32'd0);
    repeat (3) tick();
    sb_pop(32'(bus.state_o));
    sb_pop(32'(bus.perst_n));
    bus.pwr_good = 1'b1;
    sb_push("pret_release_cycles", 32'd19);
    wait_perst(1'b1, 100, n);
    sb_pop(32'(n));

    // Timeout, then link-up arriving exactly on the timeout cycle wins
    sb_push("to3_cycles", 32'd32);
    sb_push("to3_retry", 32'd1);
    wait_perst(1'b0, 100, n);
    sb_pop(32'(n));
    sb_pop(32'(bus.retry_cnt));
    sb_push("to3_reassert_cycles", 32'd16);
    wait_perst(1'b1, 100, n);
    sb_pop(32'(n));
    repeat (T_LINK_TIMEOUT - 3) tick();
    bus.link_up = 1'b1;
    sb_push("edge_state", 32'd3);
    sb_push("edge_retry", 32'd0);
    sb_push("edge_link_ok", 32'd1);
    repeat (3) tick();
    sb_pop(32'(bus.state_o));
    sb_pop(32'(bus.retry_cnt));
    sb_pop(32'(bus.link_ok));

    // Asynchronous reset between clock edges while UP
    repeat (4) tick();
    #2;
    rst = 1'b0;
    sb_push("arst_perst_n", 32'd0);
    sb_push("arst_link_ok", 32'd0);
    sb_push("arst_state", 32'd0);
    sb_push("arst_retry", 32'd0);
    sb_push("arst_fail", 32'd0);
    #1;
    sb_pop(32'(bus.perst_n));
    sb_pop(32'(bus.link_ok));
    sb_pop(32'(bus.state_o));
    sb_pop(32'(bus.retry_cnt));
    sb_pop(32'(bus.fail));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
